// File: rtl/wb_arbiter_pkg.sv
// Shared CPU constants for the write-back path: datapath widths, register count
// and the encoding of the two write-back sources.
package wb_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared when the bank commits that register; drives the decode stall.
module wb_scoreboard #(
    parameter int ADDR_W = wb_arbiter_pkg::ADDR_W,
    parameter int NREGS  = wb_arbiter_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              setEn,
    input  logic [ADDR_W-1:0] setSel,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrSel,
    input  logic [ADDR_W-1:0] srcASel,
    input  logic [ADDR_W-1:0] srcBSel,
    output logic              hazard
);
    import wb_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0] pending;

    // A set on the same edge as a clear wins: the newly issued producer is still outstanding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (setEn && setSel == ADDR_W'(i)) begin
                    pending[i] <= 1'b1;
                end else if (clrEn && clrSel == ADDR_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign hazard = (srcASel != ZERO_SEL && pending[srcASel]) ||
                    (srcBSel != ZERO_SEL && pending[srcBSel]);
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU and
// load write-back sources, with a single registered output slot.
module wb_arbiter #(
    parameter int DATA_W = wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = wb_arbiter_pkg::ADDR_W,
    parameter int NREGS  = wb_arbiter_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rf_en,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_sel,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_sel,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] srcA_sel,
    input  logic [ADDR_W-1:0] srcB_sel,
    output logic              hazard,
    output logic [DATA_W-1:0] busC,
    output logic [ADDR_W-1:0] busCsel,
    output logic              WriteC
);
    import wb_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(REG_ZERO);

    src_t              rrPtr;
    logic              slotFree;
    logic              commit;
    logic              bothValid;
    logic              grant;
    logic [ADDR_W-1:0] grantSel;
    logic [DATA_W-1:0] grantData;

    // The slot can take a new entry when empty or when its current entry commits this edge.
    always_comb begin
        slotFree  = !WriteC || rf_en;
        commit    = WriteC && rf_en;
        bothValid = alu_valid && mem_valid;
        alu_ready = reset && slotFree && alu_valid && (!mem_valid || rrPtr == SRC_ALU);
        mem_ready = reset && slotFree && mem_valid && (!alu_valid || rrPtr == SRC_MEM);
        grant     = alu_ready || mem_ready;
        grantSel  = mem_ready ? mem_sel  : alu_sel;
        grantData = mem_ready ? mem_data : alu_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busC    <= '0;
            busCsel <= '0;
            WriteC  <= 1'b0;
            rrPtr   <= SRC_ALU;
        end else begin
            if (grant && bothValid) begin
                rrPtr <= mem_ready ? SRC_ALU : SRC_MEM;
            end
            // Writes to r0 are acknowledged but never occupy the slot.
            if (grant && grantSel != ZERO_SEL) begin
                busC    <= grantData;
                busCsel <= grantSel;
                WriteC  <= 1'b1;
            end else if (commit) begin
                WriteC  <= 1'b0;
            end
        end
    end

    wb_scoreboard #(
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) uScoreboard (
        .clk    (clk),
        .reset  (reset),
        .setEn  (issue_valid),
        .setSel (issue_dest),
        .clrEn  (commit),
        .clrSel (busCsel),
        .srcASel(srcA_sel),
        .srcBSel(srcB_sel),
        .hazard (hazard)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// Cycle-by-cycle vector bench for wb_arbiter with a queue of expected bank writes.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        rf_en;
    logic        alu_valid;
    logic [4:0]  alu_sel;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_sel;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [4:0]  srcA_sel;
    logic [4:0]  srcB_sel;
    logic        hazard;
    logic [31:0] busC;
    logic [4:0]  busCsel;
    logic        WriteC;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .reset(reset), .rf_en(rf_en),
        .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .srcA_sel(srcA_sel), .srcB_sel(srcB_sel), .hazard(hazard),
        .busC(busC), .busCsel(busCsel), .WriteC(WriteC)
    );

    typedef struct {
        logic        rst, rf, av;
        logic [4:0]  as;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ms;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  id, sa, sb;
        logic        eAr, eMr, eWc;
        logic [4:0]  eSel;
        logic        eHz;
    } vec_t;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  expQ[$];
    int   passCnt  = 0;
    int   totalCnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mkv(input logic rst, rf, av, input logic [4:0] as, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] ms, input logic [31:0] md,
                                 input logic iv, input logic [4:0] id, sa, sb,
                                 input logic eAr, eMr, eWc, input logic [4:0] eSel, input logic eHz);
        vec_t v;
        v.rst = rst; v.rf = rf; v.av = av; v.as = as; v.ad = ad;
        v.mv = mv; v.ms = ms; v.md = md; v.iv = iv; v.id = id; v.sa = sa; v.sb = sb;
        v.eAr = eAr; v.eMr = eMr; v.eWc = eWc; v.eSel = eSel; v.eHz = eHz;
        return v;
    endfunction

    task automatic row(input logic rst, rf, av, input logic [4:0] as, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ms, input logic [31:0] md,
                       input logic iv, input logic [4:0] id, sa, sb,
                       input logic eAr, eMr, eWc, input logic [4:0] eSel, input logic eHz);
        vecs.push_back(mkv(rst, rf, av, as, ad, mv, ms, md, iv, id, sa, sb, eAr, eMr, eWc, eSel, eHz));
    endtask

    // Drive one cycle, check outputs mid-cycle, and track expected bank writes.
    task automatic apply(input vec_t v, input string tag);
        wr_t w;
        @(negedge clk);
        reset = v.rst; rf_en = v.rf;
        alu_valid = v.av; alu_sel = v.as; alu_data = v.ad;
        mem_valid = v.mv; mem_sel = v.ms; mem_data = v.md;
        issue_valid = v.iv; issue_dest = v.id; srcA_sel = v.sa; srcB_sel = v.sb;
        #1;
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(v.eAr));
        chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(v.eMr));
        chk({tag, ".WriteC"},    32'(WriteC),    32'(v.eWc));
        chk({tag, ".busCsel"},   32'(busCsel),   32'(v.eSel));
        chk({tag, ".hazard"},    32'(hazard),    32'(v.eHz));
        chk({tag, ".one_grant"}, 32'(alu_ready & mem_ready), 32'd0);
        if (!v.rst) begin
            expQ.delete();
        end else begin
            if (WriteC && rf_en) begin
                if (expQ.size() == 0) begin
                    chk({tag, ".unexpected_commit"}, 32'd1, 32'd0);
                end else begin
                    w = expQ.pop_front();
                    chk({tag, ".commit_sel"},  32'(busCsel), 32'(w.sel));
                    chk({tag, ".commit_data"}, busC, w.data);
                end
            end
            if (v.av && alu_ready && v.as != 5'd0) begin
                w.sel = v.as; w.data = v.ad; expQ.push_back(w);
            end
            if (v.mv && mem_ready && v.ms != 5'd0) begin
                w.sel = v.ms; w.data = v.md; expQ.push_back(w);
            end
        end
    endtask

    initial begin
        //   rst rf av as  ad            mv ms md            iv id sa sb  eAr eMr eWc eSel eHz
        row(0, 1, 1, 5,  32'h0000_0055, 0, 0, 0,            0, 0, 0, 0,  0, 0, 0, 0,  0); // r0: reset voids handshake
        row(1, 1, 1, 5,  32'hDEAD_BEEF, 0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0,  0); // single ALU write
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 1, 5,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 0, 5,  0);
        row(1, 1, 1, 1,  32'hA1A1_0001, 1, 2, 32'hB2B2_0002, 0, 0, 0, 0, 1, 0, 0, 5,  0); // contention
        row(1, 1, 1, 3,  32'hA3A3_0003, 1, 2, 32'hB2B2_0002, 0, 0, 0, 0, 0, 1, 1, 1,  0);
        row(1, 1, 1, 3,  32'hA3A3_0003, 1, 4, 32'hB4B4_0004, 0, 0, 0, 0, 1, 0, 1, 2,  0);
        row(1, 1, 1, 6,  32'hA6A6_0006, 1, 4, 32'hB4B4_0004, 0, 0, 0, 0, 0, 1, 1, 3,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 1, 4,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 0, 4,  0);
        row(1, 1, 1, 7,  32'h0000_0077, 0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 4,  0); // stall
        row(1, 0, 1, 8,  32'h0000_0088, 0, 0, 0,            0, 0, 0, 0,  0, 0, 1, 7,  0);
        row(1, 0, 1, 8,  32'h0000_0088, 0, 0, 0,            0, 0, 0, 0,  0, 0, 1, 7,  0);
        row(1, 0, 1, 8,  32'h0000_0088, 0, 0, 0,            0, 0, 0, 0,  0, 0, 1, 7,  0);
        row(1, 1, 1, 8,  32'h0000_0088, 0, 0, 0,            0, 0, 0, 0,  1, 0, 1, 7,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 1, 8,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 0, 8,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            1, 9, 9, 0,  0, 0, 0, 8,  0); // scoreboard
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 9, 0,  0, 0, 0, 8,  1);
        row(1, 1, 0, 0,  0,             1, 9, 32'h0000_0099, 0, 0, 9, 0, 0, 1, 0, 8,  1);
        row(1, 0, 0, 0,  0,             0, 0, 0,            0, 0, 9, 0,  0, 0, 1, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 9, 0,  0, 0, 1, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 9, 0,  0, 0, 0, 9,  0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            1, 9, 9, 0,  0, 0, 0, 9,  0); // set on commit edge
        row(1, 1, 0, 0,  0,             1, 9, 32'h0000_0999, 0, 0, 9, 0, 0, 1, 0, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            1, 9, 9, 0,  0, 0, 1, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 9, 0,  0, 0, 0, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 9,  0, 0, 0, 9,  1);
        row(1, 1, 1, 9,  32'h0000_0005, 0, 0, 0,            0, 0, 0, 9,  1, 0, 0, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 9,  0, 0, 1, 9,  1);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 9,  0, 0, 0, 9,  0);
        row(1, 1, 1, 0,  32'h0000_1234, 0, 0, 0,            1, 0, 0, 0,  1, 0, 0, 9,  0); // r0 writes
        row(1, 1, 0, 0,  0,             0, 0, 0,            1, 0, 0, 0,  0, 0, 0, 9,  0);
        row(1, 1, 1, 10, 32'h0000_00AA, 0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 9,  0);
        row(1, 1, 1, 0,  32'h0000_0055, 0, 0, 0,            0, 0, 0, 0,  1, 0, 1, 10, 0);
        row(1, 1, 0, 0,  0,             0, 0, 0,            0, 0, 0, 0,  0, 0, 0, 10, 0);

        reset = 1'b0; rf_en = 1'b0; alu_valid = 1'b0; alu_sel = '0; alu_data = '0;
        mem_valid = 1'b0; mem_sel = '0; mem_data = '0;
        issue_valid = 1'b0; issue_dest = '0; srcA_sel = '0; srcB_sel = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Reset while a write is held: rr first moved to MEM, write to r11 stalled, r12 pending.
        apply(mkv(1, 1, 1, 11, 32'h0000_00BB, 1, 14, 32'h0000_00EE, 0, 0, 0, 0, 1, 0, 0, 10, 0), "hold0");
        apply(mkv(1, 0, 0, 0,  0,             1, 14, 32'h0000_00EE, 1, 12, 0, 0, 0, 0, 1, 11, 0), "hold1");
        apply(mkv(0, 0, 1, 13, 32'h0000_00CC, 1, 14, 32'h0000_00EE, 0, 0, 12, 0, 0, 0, 1, 11, 1), "rstHold");
        apply(mkv(1, 1, 1, 13, 32'h0000_00CC, 1, 14, 32'h0000_00EE, 0, 0, 12, 0, 1, 0, 0, 0,  0), "postRst");
        chk("postRst.busC", busC, 32'd0);
        apply(mkv(1, 1, 0, 0,  0,             1, 14, 32'h0000_00EE, 0, 0, 0, 0,  0, 1, 1, 13, 0), "post1");
        apply(mkv(1, 1, 0, 0,  0,             0, 0,  0,             0, 0, 0, 0,  0, 0, 1, 14, 0), "post2");
        apply(mkv(1, 1, 0, 0,  0,             0, 0,  0,             0, 0, 0, 0,  0, 0, 0, 14, 0), "post3");
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
